// File: rtl/mem8_ctrl_pkg.sv
// Shared types for the 8-byte memory access controller: FSM states, default widths
// and the latched request record.
package mem8_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    VFY,
    RESP
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem8_req_t;

endpackage

// File: rtl/mem8_access_controller.sv
// Single-outstanding valid/ready front end for the 8-byte memory array; all outputs registered.
// Latency: write 2 (READ_LAT+2 with MEM8_CTRL_VERIFY_EN), read READ_LAT+1; req_ready low until the response handshake.
module mem8_access_controller
  import mem8_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] LAT_LOAD = 3'(READ_LAT - 1);

  state_e            state_q, state_d;
  mem8_req_t         req_q, req_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_d       = '{write: req_write, addr: req_addr, wdata: req_wdata};
          state_d     = req_write ? WR : RD;
          cnt_d       = LAT_LOAD;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      WR: begin
`ifdef MEM8_CTRL_VERIFY_EN
        state_d = VFY;
        cnt_d   = LAT_LOAD;
`else
        state_d = RESP;
`endif
      end
      RD, VFY: begin
        // mem_rdata is only looked at here, on the last strobe cycle, so Z never escapes
        if (cnt_q == 3'd0) begin
          rsp_rdata_d = mem_rdata;
          state_d     = RESP;
`ifdef MEM8_CTRL_VERIFY_EN
          if (state_q == VFY) rsp_err_d = (mem_rdata != req_q.wdata);
`endif
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so derive them from the state being entered.
    req_ready_d   = (state_d == IDLE);
    rsp_valid_d   = (state_d == RESP);
    mem_write_d   = (state_d == WR);
    mem_read_d    = (state_d == RD) || (state_d == VFY);
    mem_cs_d      = mem_write_d || mem_read_d;
    mem_address_d = mem_cs_d ? req_d.addr : '0;
    mem_wdata_d   = mem_write_d ? req_d.wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      req_q         <= '0;
      cnt_q         <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      mem_address_q <= '0;
      mem_cs_q      <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      mem_address_q <= mem_address_d;
      mem_cs_q      <= mem_cs_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign mem_address    = mem_address_q;
  assign mem_chipselect = mem_cs_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_wdata      = mem_wdata_q;

endmodule

// File: doc/mem8_access_controller.md
Name: mem8_access_controller

Overview:
- Bus-side controller that sits directly upstream of the 8-byte memory array. It converts single-beat valid/ready requests into the array's strobes: address, chipselect, read, write, and data.
- It captures read data from the array's shared, possibly high-impedance output, and returns it on a valid/ready response channel.
- Only one transaction is outstanding at a time, so upstream masters never see Z or strobe timing.

Parameters:
- DATA_W, 8, data width; matches the memory byte width.
- ADDR_W, 3, address width; 8 locations.
- READ_LAT, 1, number of cycles the read strobe is held before the data sample; legal range 1..7.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target location.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes unless the verify feature is enabled.
- rsp_err  out  1  readback mismatch (verify feature only; otherwise 0).
- mem_address  out  ADDR_W  to the memory address input.
- mem_chipselect  out  1  to the memory chipselect.
- mem_read  out  1  to the memory read enable.
- mem_write  out  1  to the memory write enable.
- mem_wdata  out  DATA_W  to the memory data input.
- mem_rdata  in  DATA_W  from the memory output; may be Z when not reading.

Behaviour:
- Reset values:
  - State is IDLE.
  - req_ready = 1.
  - rsp_valid = 0; rsp_rdata = 0; rsp_err = 0.
  - All mem_* strobes = 0; mem_address = 0; mem_wdata = 0.
- All outputs are registered.
- State machine:
  - IDLE:
    - req_ready = 1.
    - On req_valid && req_ready: latch addr, wdata and write, deassert req_ready, and go to WR (write) or RD (read).
  - WR:
    - Exactly 1 cycle with mem_chipselect = 1, mem_write = 1, mem_address and mem_wdata driven from the latched request.
    - The write commits at the edge that ends WR.
    - Next state: RESP, with rsp_rdata = 0, or VFY when the verify feature is enabled.
  - RD:
    - mem_chipselect = 1 and mem_read = 1 for exactly READ_LAT cycles; a 3-bit down-counter is loaded on entry.
    - mem_rdata is sampled into rsp_rdata at the edge ending the last RD cycle.
    - Next state: RESP.
  - RESP:
    - rsp_valid = 1 and rsp_rdata is held stable until rsp_ready.
    - On rsp_valid && rsp_ready: go to IDLE; rsp_valid is cleared and req_ready is set on the same edge.
- Throughput:
  - Minimum latency from request accept to rsp_valid: write 2 cycles, read READ_LAT+1 cycles.
  - Back-to-back requests require one IDLE cycle between them; there is no overlap.
- Data integrity:
  - mem_rdata is never sampled outside RD/VFY, so Z/X never propagates to rsp_rdata.
  - Strobes are 0 in IDLE and RESP.
  - Request inputs are ignored while req_ready = 0.
- Simultaneous events:
  - rsp_ready asserted before rsp_valid has no effect.
  - If req_valid arrives during RESP, it waits; it is accepted in IDLE at the earliest.
- Reset mid-operation:
  - The next edge forces IDLE and the reset values.
  - A write strobe already presented in the cycle where reset is sampled completes in the memory at that edge.
  - The in-flight response is discarded and is not replayed.
- Address wrap: not applicable; every 3-bit address is valid.

Optional Feature:
- Macro: MEM8_CTRL_VERIFY_EN.
- When defined:
  - After WR, enter VFY: the read strobe is held on the same address for READ_LAT cycles.
  - The sampled value goes to rsp_rdata.
  - rsp_err = (sample != latched wdata).
  - Then RESP. Write latency becomes READ_LAT+2.
- When undefined:
  - The VFY state is absent and WR goes directly to RESP.
  - rsp_err is tied to 0 and rsp_rdata is 0 for writes.

Decomposition:
- Package mem8_ctrl_pkg holds:
  - the state enum (IDLE, WR, RD, VFY, RESP);
  - localparams DATA_W_DEF = 8 and ADDR_W_DEF = 3;
  - a request struct {write, addr, wdata}.
- Single module. A separate sub-module is not warranted; the latency counter is inline.

Test Plan:
1. Reset, then write addr 3 = 25, then read addr 3:
   - mem_write is high for 1 cycle with mem_address = 3 and mem_wdata = 25.
   - The read response has rsp_rdata = 25 and rsp_valid READ_LAT+1 cycles after accept.
2. Write addr 2 = 15, write addr 5 = 18, then read addrs 2, 5 and 6:
   - Responses are 15, 18 and 0 (memory reset content).
   - req_ready stays low from accept until the response handshake.
3. Read addr 5 with rsp_ready held low for 6 cycles:
   - rsp_valid stays high and rsp_rdata = 18 is stable for all 6 cycles.
   - A req_valid pulse during this window is not accepted until after the handshake.
4. Assert reset during the RD of addr 3:
   - The next edge shows IDLE, req_ready = 1, rsp_valid = 0 and all strobes 0.
   - No response is issued for that read.
5. Drive mem_rdata = Z outside reads while issuing writes:
   - rsp_rdata never becomes X/Z.
   - With MEM8_CTRL_VERIFY_EN, a memory model stuck at 0 makes a write of 14 return rsp_err = 1 and rsp_rdata = 0.
6. Run READ_LAT = 3, read addr 4:
   - mem_read is high for exactly 3 cycles.
   - The sample is taken at the edge ending the third cycle.
